// File: rtl/uart_tx_queue.sv
// rtl/uart_tx_queue.sv - first-word-fall-through byte FIFO feeding the UART transmitter
// Optional synchronous flush input Clear is enabled by UART_TX_QUEUE_CLEAR_EN.
module uart_tx_queue #(
  parameter int Depth     = 8,
  parameter int DataWidth = 8
) (
  input  logic                   Clock,
  input  logic                   Reset,
  input  logic [DataWidth-1:0]   InData,
  input  logic                   InValid,
  output logic                   InReady,
  output logic [DataWidth-1:0]   OutData,
  output logic                   OutValid,
  input  logic                   OutReady,
`ifdef UART_TX_QUEUE_CLEAR_EN
  input  logic                   Clear,
`endif
  output logic [$clog2(Depth):0] Count,
  output logic                   Full,
  output logic                   Empty
);

  localparam int AW = $clog2(Depth);
  localparam logic [AW:0] DepthCount = (AW+1)'(Depth);

  logic [DataWidth-1:0] mem_q [Depth];
  logic [AW:0]          wr_ptr_q, wr_ptr_d;
  logic [AW:0]          rd_ptr_q, rd_ptr_d;
  logic                 push, pop, flush;

`ifdef UART_TX_QUEUE_CLEAR_EN
  assign flush = Clear;
`else
  assign flush = 1'b0;
`endif

  // The extra pointer MSB is the wrap bit, so full and empty stay distinct.
  assign Count    = wr_ptr_q - rd_ptr_q;
  assign Full     = (Count == DepthCount);
  assign Empty    = (Count == '0);
  assign InReady  = !Full;
  assign OutValid = !Empty;
  assign OutData  = mem_q[rd_ptr_q[AW-1:0]];

  assign push = InValid && InReady;
  assign pop  = OutValid && OutReady;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // A write during a flush lands in a slot the reset pointers no longer cover.
  always_ff @(posedge Clock) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= InData;
  end

endmodule
